// File: rtl/sd_stream_pkg.sv
// Shared constants, error codes, state encoding and the bus request payload
// for the SD sector streamer.
package sd_stream_pkg;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    localparam logic [AW-1:0] ADDR_ARG = 8'h8B;
    localparam logic [AW-1:0] ADDR_CMD = 8'h8C;
    localparam logic [AW-1:0] ADDR_ASR = 8'h8D;
    localparam logic [DW-1:0] CMD_READ_BLOCK = 32'h11;

    localparam int unsigned ASR_CMD_VALID    = 0;
    localparam int unsigned ASR_CARD_PRESENT = 1;
    localparam int unsigned ASR_CMD_BUSY     = 2;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_NO_CARD  = 2'd1;
    localparam logic [1:0] ERR_CMD_FAIL = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE, ST_CHK, ST_ARG, ST_CMD, ST_POLL,
        ST_RDW, ST_EMIT, ST_NEXT, ST_DONE, ST_ERROR
    } state_t;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } xfer_req_t;

endpackage

// File: rtl/avmm_single_xfer.sv
// Issues a single Avalon-MM read or write, holds it through waitrequest and
// reports completion with a one-cycle done pulse plus the captured read data.
module avmm_single_xfer
    import sd_stream_pkg::*;
(
    input  logic          CLOCK_50,
    input  logic          delayed_reset,
    input  logic          start,
    input  logic          abort,
    input  xfer_req_t     req,
    input  logic [DW-1:0] av_rdata,
    input  logic          av_wait,
    output logic          av_cs,
    output logic          av_rd,
    output logic          av_wr,
    output logic [AW-1:0] av_addr,
    output logic [DW-1:0] av_wdata,
    output logic          done,
    output logic [DW-1:0] rdata
);

    always_ff @(posedge CLOCK_50 or posedge delayed_reset) begin
        if (delayed_reset) begin
            av_cs    <= 1'b0;
            av_rd    <= 1'b0;
            av_wr    <= 1'b0;
            av_addr  <= '0;
            av_wdata <= '0;
            done     <= 1'b0;
            rdata    <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                av_cs <= 1'b0;
                av_rd <= 1'b0;
                av_wr <= 1'b0;
            end else if (av_cs) begin
                // transfer completes in the first cycle without waitrequest
                if (!av_wait) begin
                    av_cs <= 1'b0;
                    av_rd <= 1'b0;
                    av_wr <= 1'b0;
                    done  <= 1'b1;
                    if (av_rd) rdata <= av_rdata;
                end
            end else if (start) begin
                av_cs    <= 1'b1;
                av_rd    <= !req.wr;
                av_wr    <= req.wr;
                av_addr  <= req.addr;
                av_wdata <= req.wdata;
            end
        end
    end

endmodule

// File: rtl/sd_sector_streamer.sv
// Reads consecutive 512-byte sectors from the SD-card Avalon slave and streams
// them out as a little-endian valid/ready byte stream.
module sd_sector_streamer
    import sd_stream_pkg::*;
#(
    parameter int unsigned POLL_TIMEOUT = 50_000_000,
    parameter bit          BYTE_ADDR    = 1'b1
) (
    input  logic          CLOCK_50,
    input  logic          delayed_reset,
    input  logic          iSTART,
    input  logic [31:0]   iSECTOR,
    input  logic [15:0]   iCOUNT,
    output logic          oAV_CS,
    output logic [AW-1:0] oAV_ADDR,
    output logic          oAV_RD,
    output logic          oAV_WR,
    output logic [3:0]    oAV_BE,
    output logic [DW-1:0] oAV_WDATA,
    input  logic [DW-1:0] iAV_RDATA,
    input  logic          iAV_WAIT,
    output logic [7:0]    oDATA,
    output logic          oVALID,
    input  logic          iREADY,
    output logic          oBUSY,
    output logic          oDONE,
    output logic [1:0]    oERR
);

    localparam int unsigned TW = $clog2(POLL_TIMEOUT + 1);

    state_t        state, state_n;
    logic [31:0]   sector, sector_n;
    logic [15:0]   remain, remain_n;
    logic [6:0]    idx, idx_n;
    logic [1:0]    byte_cnt, byte_n;
    logic [DW-1:0] shreg, shreg_n;
    logic [TW-1:0] tmo, tmo_n;
    logic          issued, issued_n;
    logic [1:0]    err_n;
    logic          xfer_start, xfer_abort, xfer_done;
    logic [DW-1:0] xfer_rdata;
    xfer_req_t     req;

    avmm_single_xfer u_xfer (
        .CLOCK_50      (CLOCK_50),
        .delayed_reset (delayed_reset),
        .start         (xfer_start),
        .abort         (xfer_abort),
        .req           (req),
        .av_rdata      (iAV_RDATA),
        .av_wait       (iAV_WAIT),
        .av_cs         (oAV_CS),
        .av_rd         (oAV_RD),
        .av_wr         (oAV_WR),
        .av_addr       (oAV_ADDR),
        .av_wdata      (oAV_WDATA),
        .done          (xfer_done),
        .rdata         (xfer_rdata)
    );

    always_ff @(posedge CLOCK_50 or posedge delayed_reset) begin
        if (delayed_reset) begin
            state    <= ST_IDLE;
            sector   <= '0;
            remain   <= '0;
            idx      <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            tmo      <= '0;
            issued   <= 1'b0;
            oERR     <= ERR_NONE;
            oVALID   <= 1'b0;
            oDATA    <= '0;
            oBUSY    <= 1'b0;
            oDONE    <= 1'b0;
            oAV_BE   <= '0;
        end else begin
            state    <= state_n;
            sector   <= sector_n;
            remain   <= remain_n;
            idx      <= idx_n;
            byte_cnt <= byte_n;
            shreg    <= shreg_n;
            tmo      <= tmo_n;
            issued   <= issued_n;
            oERR     <= err_n;
            oVALID   <= (state_n == ST_EMIT);
            oDATA    <= (state_n == ST_EMIT) ? shreg_n[7:0] : 8'd0;
            oBUSY    <= !(state_n inside {ST_IDLE, ST_DONE, ST_ERROR});
            oDONE    <= (state_n == ST_DONE);
            oAV_BE   <= 4'hF;
        end
    end

    // next-state, datapath and bus-request decode
    always_comb begin
        state_n    = state;
        sector_n   = sector;
        remain_n   = remain;
        idx_n      = idx;
        byte_n     = byte_cnt;
        shreg_n    = shreg;
        tmo_n      = tmo;
        issued_n   = issued;
        err_n      = oERR;
        xfer_start = 1'b0;
        xfer_abort = 1'b0;
        req        = '0;
        req.addr   = ADDR_ASR;

        unique case (state)
            ST_IDLE: if (iSTART) begin
                sector_n = iSECTOR;
                remain_n = iCOUNT;
                err_n    = ERR_NONE;
                state_n  = (iCOUNT == 16'd0) ? ST_DONE : ST_CHK;
            end
            ST_CHK: if (xfer_done) begin
                if (xfer_rdata[ASR_CARD_PRESENT]) begin
                    state_n = ST_ARG;
                end else begin
                    state_n = ST_ERROR;
                    err_n   = ERR_NO_CARD;
                end
            end
            ST_ARG: begin
                req.wr    = 1'b1;
                req.addr  = ADDR_ARG;
                req.wdata = BYTE_ADDR ? {sector[22:0], 9'b0} : sector;
                if (xfer_done) state_n = ST_CMD;
            end
            ST_CMD: begin
                req.wr    = 1'b1;
                req.addr  = ADDR_CMD;
                req.wdata = CMD_READ_BLOCK;
                tmo_n     = '0;
                if (xfer_done) state_n = ST_POLL;
            end
            ST_POLL: begin
                tmo_n = tmo + TW'(1);
                if (tmo == TW'(POLL_TIMEOUT - 1)) begin
                    xfer_abort = 1'b1;
                    state_n    = ST_ERROR;
                    err_n      = ERR_TIMEOUT;
                end else if (xfer_done && !xfer_rdata[ASR_CMD_BUSY]) begin
                    if (xfer_rdata[ASR_CMD_VALID]) begin
                        state_n = ST_RDW;
                        idx_n   = '0;
                    end else begin
                        state_n = ST_ERROR;
                        err_n   = ERR_CMD_FAIL;
                    end
                end
            end
            ST_RDW: begin
                req.addr = AW'({1'b0, idx});
                if (xfer_done) begin
                    shreg_n = xfer_rdata;
                    byte_n  = '0;
                    state_n = ST_EMIT;
                end
            end
            ST_EMIT: if (iREADY) begin
                shreg_n = {8'd0, shreg[DW-1:8]};
                byte_n  = byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    if (idx == 7'd127) begin
                        state_n = ST_NEXT;
                    end else begin
                        idx_n   = idx + 7'd1;
                        state_n = ST_RDW;
                    end
                end
            end
            ST_NEXT: begin
                sector_n = sector + 32'd1;
                remain_n = remain - 16'd1;
                state_n  = (remain == 16'd1) ? ST_DONE : ST_ARG;
            end
            ST_DONE:  state_n = ST_IDLE;
            ST_ERROR: state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase

        // one bus transfer per visit; POLL re-arms after every completed read
        if (state inside {ST_CHK, ST_ARG, ST_CMD, ST_POLL, ST_RDW}) begin
            if (xfer_done || xfer_abort) begin
                issued_n = 1'b0;
            end else if (!issued) begin
                xfer_start = 1'b1;
                issued_n   = 1'b1;
            end
        end
    end

endmodule
